// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide backing array between the I-cache
// and D-cache fill/writeback ports with round-robin arbitration.
module mem_arbiter #(
    parameter int CACHE_LINE_SIZE = 128,
    parameter int MEM_LATENCY     = 5,
    parameter int MEM_DEPTH       = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_i_read_en,
    input  logic [31:0]                in_i_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
    output logic                       out_i_ready,
    input  logic                       in_d_read_en,
    input  logic                       in_d_write_en,
    input  logic [31:0]                in_d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
    output logic                       out_d_ready,
    output logic                       out_busy
);

    localparam int OFF_W = $clog2(CACHE_LINE_SIZE / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RESP
    } state_e;

    state_e                     state_q;
    logic [3:0]                 cnt_q;
    logic                       gnt_d_q;
    logic                       last_d_q;
    logic                       wr_q;
    logic [IDX_W-1:0]           idx_q;
    logic [CACHE_LINE_SIZE-1:0] wdata_q;
    logic [CACHE_LINE_SIZE-1:0] i_rdata_q;
    logic [CACHE_LINE_SIZE-1:0] d_rdata_q;
    logic                       i_rdy_q;
    logic                       d_rdy_q;
    logic                       busy_q;

    logic [CACHE_LINE_SIZE-1:0] mem_q [MEM_DEPTH];

    logic             i_req_d;
    logic             d_req_d;
    logic             pick_d_d;
    logic             access_d;
    logic [IDX_W-1:0] idx_i_d;
    logic [IDX_W-1:0] idx_d_d;
    logic             unused_addr;

    // Offset bits drop out of the line index; upper bits wrap by truncation.
    assign idx_i_d = in_i_addr[OFF_W +: IDX_W];
    assign idx_d_d = in_d_addr[OFF_W +: IDX_W];
    assign unused_addr = ^{in_i_addr, in_d_addr};

    // Arbitration: a lone requester wins; on a tie the side not served last wins.
    always_comb begin
        i_req_d  = in_i_read_en;
        d_req_d  = in_d_read_en | in_d_write_en;
        pick_d_d = d_req_d & (~i_req_d | ~last_d_q);
        access_d = (state_q == SERVE) && (cnt_q == 4'd0);
    end

    // Transaction FSM with registered ready, busy and read-data outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            gnt_d_q   <= 1'b0;
            last_d_q  <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_req_d || d_req_d) begin
                        state_q  <= SERVE;
                        busy_q   <= 1'b1;
                        cnt_q    <= CNT_LOAD;
                        gnt_d_q  <= pick_d_d;
                        last_d_q <= pick_d_d;
                        wr_q     <= pick_d_d & in_d_write_en;
                        idx_q    <= pick_d_d ? idx_d_d : idx_i_d;
                        wdata_q  <= in_d_write_data;
                    end
                end
                SERVE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        i_rdy_q <= ~gnt_d_q;
                        d_rdy_q <= gnt_d_q;
                        if (!wr_q) begin
                            if (gnt_d_q) begin
                                d_rdata_q <= mem_q[idx_q];
                            end else begin
                                i_rdata_q <= mem_q[idx_q];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    i_rdy_q <= 1'b0;
                    d_rdy_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Backing array: written once per write transaction, never reset.
    always_ff @(posedge clk) begin
        if (access_d && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign out_i_read_data = i_rdata_q;
    assign out_d_read_data = d_rdata_q;
    assign out_i_ready     = i_rdy_q;
    assign out_d_ready     = d_rdy_q;
    assign out_busy        = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CACHE_LINE_SIZE, default 128, meaning line width in bits on both cache ports.
REQ-002 SHALL have parameter MEM_LATENCY, default 5, meaning cycles from accepted request to ready; legal range 2..15.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, meaning number of lines in the backing array; power of two.
REQ-004 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_i_read_en input 1: I-cache line fill request.
REQ-007 SHALL have port in_i_addr input 32: I-cache request byte address.
REQ-008 SHALL have port out_i_read_data output CACHE_LINE_SIZE: I-side fill line.
REQ-009 SHALL have port out_i_ready output 1: I-side completion pulse.
REQ-010 SHALL have port in_d_read_en input 1: D-cache line fill request.
REQ-011 SHALL have port in_d_write_en input 1: D-cache line writeback request.
REQ-012 SHALL have port in_d_addr input 32: D-cache request byte address.
REQ-013 SHALL have port in_d_write_data input CACHE_LINE_SIZE: writeback line.
REQ-014 SHALL have port out_d_read_data output CACHE_LINE_SIZE: D-side fill line.
REQ-015 SHALL have port out_d_ready output 1: D-side completion pulse.
REQ-016 SHALL have port out_busy output 1: high whenever the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, SERVE, RESP.
REQ-018 In IDLE with exactly one side requesting, SHALL grant it; with both requesting, SHALL grant the side not granted most recently (round-robin); with none, SHALL stay in IDLE.
REQ-019 On grant, SHALL latch the requester, operation, line index, and write data, load the counter with MEM_LATENCY-2, and enter SERVE; inputs are ignored until the next IDLE.
REQ-020 Line index SHALL be addr bits starting at log2(CACHE_LINE_SIZE/8), width log2(MEM_DEPTH); offset bits are ignored and higher bits wrap modulo MEM_DEPTH.
REQ-021 In SERVE, the counter SHALL decrement each cycle; at 0, SHALL perform the array access on that edge and enter RESP.
REQ-022 If in_d_write_en and in_d_read_en are both high at grant, SHALL perform the write only.
REQ-023 A write SHALL update the array at the SERVE-to-RESP edge and be visible to any later-granted read.
REQ-024 A read SHALL register the line into the granted side's read-data register at the same edge; the other side's register SHALL be unchanged.
REQ-025 In RESP, SHALL assert exactly the granted side's ready for one cycle, then return to IDLE.
REQ-026 A request seen in IDLE in cycle t SHALL produce ready in cycle t+MEM_LATENCY.
REQ-027 Read-data registers SHALL hold their value until that side's next read completion.
REQ-028 The requester SHALL hold its request and data stable until its ready and deassert it in the following cycle; the arbiter does not check this.
REQ-029 The arbiter SHALL issue no more than one array access per transaction.

Reset
REQ-030 While reset is low: state IDLE, counter 0, out_i_ready=0, out_d_ready=0, out_busy=0, both read-data outputs 0, last-grant=I so D wins the first tie.
REQ-031 Reset asserted mid-SERVE SHALL abort the transaction with no array write and no ready pulse.
REQ-032 Array contents SHALL NOT be reset.

Verification
REQ-033 Write D line 0x...AA at addr 0x40, then read D at 0x4C -> out_d_ready 5 cycles after each request; out_d_read_data = 0x...AA.
REQ-034 I and D both request in the same IDLE cycle after reset -> D completes at t+5; I is granted at the next IDLE and completes 5 cycles after it.
REQ-035 Both sides request continuously for 4 transactions -> grants alternate D, I, D, I.
REQ-036 Read I at addr 0x40 + MEM_DEPTH*16 after writing 0x40 -> returns the written line (wrap).
REQ-037 Reset low 2 cycles into a D write -> no ready pulse; a subsequent read returns the old contents; outputs are 0 during reset.
REQ-038 D read/write both high -> write performed; out_d_read_data is unchanged at ready.
